// File: rtl/tessent_data_mux_ctrl_pkg.sv
// Shared types and constants for the IJTAG data mux takeover controller.
package tessent_data_mux_ctrl_pkg;

    typedef enum logic [2:0] {
        FUNC       = 3'd0,
        QREQ       = 3'd1,
        SETTLE_IN  = 3'd2,
        TAKEN      = 3'd3,
        SETTLE_OUT = 3'd4
    } state_t;

    // Two control bits sit above the data field in both the capture and update words.
    localparam int TDR_CTRL_BITS = 2;

    function automatic int tdr_len(input int dw);
        return dw + TDR_CTRL_BITS;
    endfunction

    // Capture: timeout_err / update: err_clear.
    function automatic int err_bit(input int dw);
        return dw + 1;
    endfunction

    // Capture: active / update: takeover_req.
    function automatic int ctl_bit(input int dw);
        return dw;
    endfunction

    function automatic int cnt_width(input int settle, input int ack);
        int m;
        m = (settle > ack) ? settle : ack;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/tessent_data_mux_ctrl_if.sv
// IJTAG segment access port of the TDR: the network drives, the instrument returns scan-out.
interface tessent_data_mux_ctrl_if;
    logic ijtag_sel;
    logic ijtag_si;
    logic ijtag_ce;
    logic ijtag_se;
    logic ijtag_ue;
    logic ijtag_so;

    modport master (
        output ijtag_sel, ijtag_si, ijtag_ce, ijtag_se, ijtag_ue,
        input  ijtag_so
    );

    modport slave (
        input  ijtag_sel, ijtag_si, ijtag_ce, ijtag_se, ijtag_ue,
        output ijtag_so
    );
endinterface

// File: rtl/tessent_data_mux_ctrl_tdr.sv
// Capture/shift/update data register: status capture, pattern and takeover-request update.
module tessent_data_mux_ctrl_tdr
    import tessent_data_mux_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 3
) (
    input  logic                   ijtag_tck,
    input  logic                   ijtag_reset,
    tessent_data_mux_ctrl_if.slave tdr_if,
    input  logic                   timeout_err,
    input  logic                   active,
    input  logic [DATA_WIDTH-1:0]  data_out_observe,
    output logic                   takeover_req,
    output logic                   err_clear,
    output logic [DATA_WIDTH-1:0]  update_data
);

    localparam int L       = tdr_len(DATA_WIDTH);
    localparam int ERR_BIT = err_bit(DATA_WIDTH);
    localparam int CTL_BIT = ctl_bit(DATA_WIDTH);

    logic [L-1:0] shift_reg;
    logic [L-1:0] capture_word;
    logic         capture_en;
    logic         shift_en;
    logic         update_en;

    // Capture beats shift, shift beats update, all gated by segment select.
    assign capture_en = tdr_if.ijtag_sel & tdr_if.ijtag_ce;
    assign shift_en   = tdr_if.ijtag_sel & tdr_if.ijtag_se & ~tdr_if.ijtag_ce;
    assign update_en  = tdr_if.ijtag_sel & tdr_if.ijtag_ue & ~tdr_if.ijtag_ce & ~tdr_if.ijtag_se;

    always_comb begin
        capture_word                   = '0;
        capture_word[ERR_BIT]          = timeout_err;
        capture_word[CTL_BIT]          = active;
        capture_word[DATA_WIDTH-1:0]   = data_out_observe;
    end

    always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
        if (!ijtag_reset) begin
            shift_reg    <= '0;
            takeover_req <= 1'b0;
            update_data  <= '0;
        end else if (capture_en) begin
            shift_reg <= capture_word;
        end else if (shift_en) begin
            shift_reg <= {tdr_if.ijtag_si, shift_reg[L-1:1]};
        end else if (update_en) begin
            takeover_req <= shift_reg[CTL_BIT];
            update_data  <= shift_reg[DATA_WIDTH-1:0];
        end
    end

    // err_clear is never stored; it only acts on the update edge itself.
    assign err_clear      = update_en & shift_reg[ERR_BIT];
    assign tdr_if.ijtag_so = shift_reg[0];

endmodule

// File: rtl/tessent_data_mux_ctrl.sv
// Takeover sequencer for a functional/IJTAG data mux: quiesce handshake,
// settle windows around each select change, and the access TDR.
module tessent_data_mux_ctrl
    import tessent_data_mux_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH    = 3,
    parameter int SETTLE_CYCLES = 4,
    parameter int ACK_TIMEOUT   = 64
) (
    input  logic                   ijtag_tck,
    input  logic                   ijtag_reset,
    tessent_data_mux_ctrl_if.slave tdr_if,
    output logic                   func_quiesce_req,
    input  logic                   func_quiesce_ack,
    input  logic [DATA_WIDTH-1:0]  data_out_observe,
    output logic                   ijtag_select,
    output logic [DATA_WIDTH-1:0]  ijtag_data_in,
    output state_t                 dbg_state
);

    localparam int           CW          = cnt_width(SETTLE_CYCLES, ACK_TIMEOUT);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] ACK_LAST    = CW'(ACK_TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX     = '1;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         cnt_inc;
    logic                  timeout_err;
    logic                  timeout_hit;
    logic                  takeover_req;
    logic                  err_clear;
    logic [DATA_WIDTH-1:0] update_data;

    tessent_data_mux_ctrl_tdr #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_tdr (
        .ijtag_tck        (ijtag_tck),
        .ijtag_reset      (ijtag_reset),
        .tdr_if           (tdr_if),
        .timeout_err      (timeout_err),
        .active           (state == TAKEN),
        .data_out_observe (data_out_observe),
        .takeover_req     (takeover_req),
        .err_clear        (err_clear),
        .update_data      (update_data)
    );

    assign cnt_inc     = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    assign timeout_hit = (state == QREQ) & ~func_quiesce_ack & (cnt >= ACK_LAST);

    // Quiesce handshake: req rises on leaving FUNC and stays high until the
    // sequence is back in FUNC; ack is only sampled in QREQ, so a late drop of
    // ack never aborts a takeover already under way.
    always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
        if (!ijtag_reset) begin
            state            <= FUNC;
            cnt              <= '0;
            ijtag_select     <= 1'b0;
            func_quiesce_req <= 1'b0;
        end else begin
            case (state)
                FUNC: begin
                    if (takeover_req) begin
                        state            <= QREQ;
                        cnt              <= '0;
                        func_quiesce_req <= 1'b1;
                    end
                end
                QREQ: begin
                    if (func_quiesce_ack) begin
                        state        <= SETTLE_IN;
                        cnt          <= '0;
                        ijtag_select <= 1'b1;
                    end else if (timeout_hit || !takeover_req) begin
                        state            <= FUNC;
                        cnt              <= '0;
                        func_quiesce_req <= 1'b0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                SETTLE_IN: begin
                    if (cnt >= SETTLE_LAST) begin
                        state <= TAKEN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                TAKEN: begin
                    if (!takeover_req) begin
                        state        <= SETTLE_OUT;
                        cnt          <= '0;
                        ijtag_select <= 1'b0;
                    end
                end
                SETTLE_OUT: begin
                    if (cnt >= SETTLE_LAST) begin
                        state            <= FUNC;
                        cnt              <= '0;
                        func_quiesce_req <= 1'b0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    state            <= FUNC;
                    cnt              <= '0;
                    ijtag_select     <= 1'b0;
                    func_quiesce_req <= 1'b0;
                end
            endcase
        end
    end

    // A timeout landing on the same edge as a clear must stay visible.
    always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
        if (!ijtag_reset) begin
            timeout_err <= 1'b0;
        end else if (timeout_hit) begin
            timeout_err <= 1'b1;
        end else if (err_clear) begin
            timeout_err <= 1'b0;
        end
    end

    assign ijtag_data_in = update_data;
    assign dbg_state     = state;

endmodule

// File: tb/tb_tessent_data_mux_ctrl.sv
// Self-checking bench for tessent_data_mux_ctrl: TDR vectors, randomized takeovers, timeout/clear and reset corners.
module tb_tessent_data_mux_ctrl;
  import tessent_data_mux_ctrl_pkg::*;

  localparam int DW     = 3;
  localparam int SETTLE = 4;
  localparam int ACK_TO = 64;
  localparam int L      = DW + 2;

  // ---------------- clock / reset ----------------
  logic ijtag_tck   = 1'b0;
  logic ijtag_reset = 1'b0;
  always #5 ijtag_tck = ~ijtag_tck;

  logic          func_quiesce_req;
  logic          func_quiesce_ack = 1'b0;
  logic [DW-1:0] data_out_observe = '0;
  logic          ijtag_select;
  logic [DW-1:0] ijtag_data_in;
  state_t        dbg_state;

  tessent_data_mux_ctrl_if tdr_if();

  tessent_data_mux_ctrl #(
    .DATA_WIDTH    (DW),
    .SETTLE_CYCLES (SETTLE),
    .ACK_TIMEOUT   (ACK_TO)
  ) dut (
    .ijtag_tck        (ijtag_tck),
    .ijtag_reset      (ijtag_reset),
    .tdr_if           (tdr_if),
    .func_quiesce_req (func_quiesce_req),
    .func_quiesce_ack (func_quiesce_ack),
    .data_out_observe (data_out_observe),
    .ijtag_select     (ijtag_select),
    .ijtag_data_in    (ijtag_data_in),
    .dbg_state        (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int fails  = 0;
  logic [L-1:0] exp_q[$];
  bit err_m = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [L-1:0] model_capture(input bit err, input bit act, input logic [DW-1:0] obs);
    return {err, act, obs};
  endfunction

  // Negedges from first seeing quiesce_req high to first seeing select high,
  // when ack is raised after d cycles; -1 means the request times out instead.
  function automatic int model_select_latency(input int d);
    if (d + 1 <= ACK_TO) return d + 1;
    return -1;
  endfunction

  // ---------------- drivers ----------------
  task automatic scan(input logic [L-1:0] din, input bit do_update, output logic [L-1:0] dout);
    tdr_if.ijtag_sel = 1'b1;
    tdr_if.ijtag_ce  = 1'b1;
    @(negedge ijtag_tck);
    tdr_if.ijtag_ce = 1'b0;
    tdr_if.ijtag_se = 1'b1;
    for (int i = 0; i < L; i++) begin
      dout[i]         = tdr_if.ijtag_so;
      tdr_if.ijtag_si = din[i];
      @(negedge ijtag_tck);
    end
    tdr_if.ijtag_se = 1'b0;
    tdr_if.ijtag_si = 1'b0;
    tdr_if.ijtag_ue = do_update;
    @(negedge ijtag_tck);
    tdr_if.ijtag_ue  = 1'b0;
    tdr_if.ijtag_sel = 1'b0;
  endtask

  task automatic scan_expect(input string name, input logic [L-1:0] din, input bit do_update,
                             input logic [L-1:0] exp_cap);
    logic [L-1:0] dout;
    logic [L-1:0] exp;
    exp_q.push_back(exp_cap);
    scan(din, do_update, dout);
    exp = exp_q.pop_front();
    check(name, dout, exp);
  endtask

  task automatic takeover_trial(input int d, input logic [DW-1:0] data, input logic [DW-1:0] obs,
                                input bit settle_probe);
    int lat;
    data_out_observe = obs;
    func_quiesce_ack = 1'b0;
    scan_expect("trial_idle_cap", {2'b01, data}, 1'b1, model_capture(err_m, 1'b0, obs));
    @(negedge ijtag_tck);
    check("trial_req_rise", func_quiesce_req, 1);
    check("trial_sel_low_in_qreq", ijtag_select, 0);
    lat = 0;
    repeat (d) begin
      @(negedge ijtag_tck);
      lat++;
    end
    func_quiesce_ack = 1'b1;
    while (ijtag_select !== 1'b1 && lat < 200) begin
      @(negedge ijtag_tck);
      lat++;
    end
    func_quiesce_ack = 1'b0;
    check("trial_select_latency", lat, model_select_latency(d));
    if (settle_probe) begin
      repeat (SETTLE - 1) @(negedge ijtag_tck);
      scan_expect("settle_in_cap", {2'b01, data}, 1'b0, model_capture(err_m, 1'b0, obs));
    end else begin
      repeat (SETTLE) @(negedge ijtag_tck);
    end
    scan_expect("taken_cap", {2'b01, data}, 1'b0, model_capture(err_m, 1'b1, obs));
    check("taken_data_in", ijtag_data_in, data);
    check("taken_select", ijtag_select, 1);
    check("taken_req", func_quiesce_req, 1);
    scan_expect("release_cap", {2'b00, data}, 1'b1, model_capture(err_m, 1'b1, obs));
    check("release_select_held", ijtag_select, 1);
    @(negedge ijtag_tck);
    check("release_select_fall", ijtag_select, 0);
    check("release_req_held", func_quiesce_req, 1);
    lat = 0;
    while (func_quiesce_req === 1'b1 && lat < 50) begin
      @(negedge ijtag_tck);
      lat++;
    end
    check("release_req_latency", lat, SETTLE);
    check("release_state", dbg_state, FUNC);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [DW-1:0] obs;
    logic [L-1:0]  din;
    logic [L-1:0]  exp_cap;
    logic [DW-1:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    bit sel_seen;
    logic [DW-1:0] rd;
    logic [DW-1:0] ro;

    vecs[0] = '{3'b000, 5'b00_111, 5'b00_000, 3'b111};
    vecs[1] = '{3'b111, 5'b00_010, 5'b00_111, 3'b010};
    vecs[2] = '{3'b010, 5'b00_101, 5'b00_010, 3'b101};
    vecs[3] = '{3'b110, 5'b00_000, 5'b00_110, 3'b000};
    vecs[4] = '{3'b011, 5'b10_001, 5'b00_011, 3'b001};
    vecs[5] = '{3'b100, 5'b00_011, 5'b00_100, 3'b011};

    tdr_if.ijtag_sel = 1'b0;
    tdr_if.ijtag_si  = 1'b0;
    tdr_if.ijtag_ce  = 1'b0;
    tdr_if.ijtag_se  = 1'b0;
    tdr_if.ijtag_ue  = 1'b0;

    // Reset state
    repeat (3) @(negedge ijtag_tck);
    check("rst_select", ijtag_select, 0);
    check("rst_req", func_quiesce_req, 0);
    check("rst_so", tdr_if.ijtag_so, 0);
    check("rst_data_in", ijtag_data_in, 0);
    check("rst_state", dbg_state, FUNC);
    ijtag_reset = 1'b1;
    @(negedge ijtag_tck);
    data_out_observe = 3'b101;
    scan_expect("reset_capture", 5'b00_000, 1'b1, 5'b00101);

    // Table-driven TDR vectors
    for (int i = 0; i < 6; i++) begin
      data_out_observe = vecs[i].obs;
      scan_expect("vec_capture", vecs[i].din, 1'b1, vecs[i].exp_cap);
      check("vec_data_in", ijtag_data_in, vecs[i].exp_data);
      check("vec_so", tdr_if.ijtag_so, vecs[i].din[0]);
      check("vec_select", ijtag_select, 0);
    end

    // Randomized capture / update traffic with no takeover
    for (int i = 0; i < 12; i++) begin
      ro = DW'($urandom_range(0, 7));
      rd = DW'($urandom_range(0, 7));
      data_out_observe = ro;
      scan_expect("rand_capture", {2'b00, rd}, 1'b1, model_capture(err_m, 1'b0, ro));
      check("rand_data_in", ijtag_data_in, rd);
    end

    // Directed takeover, then randomized ack delays, then the last-cycle ack
    takeover_trial(2, 3'b110, 3'b101, 1'b1);
    for (int i = 0; i < 4; i++) begin
      takeover_trial($urandom_range(0, 12), DW'($urandom_range(0, 7)), DW'($urandom_range(0, 7)), 1'b0);
    end
    takeover_trial(ACK_TO - 1, 3'b011, 3'b010, 1'b0);

    // Ack never arrives
    data_out_observe = 3'b011;
    func_quiesce_ack = 1'b0;
    scan_expect("to_idle_cap", {2'b01, 3'b001}, 1'b1, model_capture(err_m, 1'b0, 3'b011));
    @(negedge ijtag_tck);
    hi = 0;
    sel_seen = 1'b0;
    while (func_quiesce_req === 1'b1 && hi < 200) begin
      if (ijtag_select !== 1'b0) sel_seen = 1'b1;
      hi++;
      @(negedge ijtag_tck);
    end
    check("timeout_req_width", hi, ACK_TO);
    check("timeout_no_select", sel_seen, 0);
    err_m = 1'b1;
    scan_expect("timeout_err_cap", {2'b00, 3'b001}, 1'b1, model_capture(err_m, 1'b0, 3'b011));
    repeat (2) @(negedge ijtag_tck);
    check("timeout_stop_req", func_quiesce_req, 0);
    check("timeout_stop_state", dbg_state, FUNC);

    // err_clear
    scan_expect("clear_cap", {2'b10, 3'b000}, 1'b1, model_capture(err_m, 1'b0, 3'b011));
    err_m = 1'b0;
    scan_expect("after_clear_cap", {2'b00, 3'b000}, 1'b1, model_capture(err_m, 1'b0, 3'b011));

    // Clear landing on the timeout edge: update edge lands 64 edges after req rises
    scan_expect("sim_idle_cap", {2'b01, 3'b010}, 1'b1, model_capture(err_m, 1'b0, 3'b011));
    repeat (ACK_TO - 6) @(negedge ijtag_tck);
    scan_expect("sim_clear_cap", {2'b11, 3'b010}, 1'b1, model_capture(err_m, 1'b0, 3'b011));
    err_m = 1'b1;
    scan_expect("sim_result_cap", {2'b00, 3'b010}, 1'b1, model_capture(err_m, 1'b0, 3'b011));
    repeat (2) @(negedge ijtag_tck);
    check("sim_stop_req", func_quiesce_req, 0);
    scan_expect("sim_clear2_cap", {2'b10, 3'b000}, 1'b1, model_capture(err_m, 1'b0, 3'b011));
    err_m = 1'b0;

    // Asynchronous reset during SETTLE_IN
    scan_expect("arst_idle_cap", {2'b01, 3'b111}, 1'b1, model_capture(err_m, 1'b0, 3'b011));
    @(negedge ijtag_tck);
    func_quiesce_ack = 1'b1;
    @(negedge ijtag_tck);
    func_quiesce_ack = 1'b0;
    check("arst_pre_select", ijtag_select, 1);
    #2 ijtag_reset = 1'b0;
    #1;
    check("arst_select_async", ijtag_select, 0);
    check("arst_req_async", func_quiesce_req, 0);
    check("arst_state_async", dbg_state, FUNC);
    @(negedge ijtag_tck);
    ijtag_reset = 1'b1;
    repeat (6) @(negedge ijtag_tck);
    check("arst_post_select", ijtag_select, 0);
    check("arst_post_req", func_quiesce_req, 0);
    check("arst_post_data_in", ijtag_data_in, 0);
    check("arst_post_state", dbg_state, FUNC);
    scan_expect("arst_post_cap", 5'b00_000, 1'b0, model_capture(1'b0, 1'b0, 3'b011));

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
